instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Producer side of the instruction bus feeding the single-cycle CPU instruction decoder.
//  Owns the PC; fetches words from instruction memory over a req/ready handshake.
//  Presents instruction + instr_valid to the decoder; on retire applies decoder controls (jump/jr/branch) to pick next PC.
//  Sits between imem and instructiondecoder/datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; low 2 bits must be 0
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  byte address of requested word (= pc)
//  imem_ready   in   1   imem_rdata valid this cycle; only honoured while imem_req=1
//  imem_rdata   in   32  fetched instruction word
//  instruction  out  32  registered instruction to decoder
//  instr_valid  out  1   instruction held and valid for decode
//  pc_out       out  32  address of held instruction
//  pc_plus4     out  32  pc_out+4 (JAL link value)
//  retire       in   1   datapath finished held instruction; controls below valid this cycle
//  branch       in   1   decoder branch (BNE)
//  alu_zero     in   1   ALU zero flag; BNE taken = branch & ~alu_zero
//  jump         in   1   decoder jump (J, JAL)
//  jr           in   1   decoder jr
//  jr_target    in   32  register value for JR
//  align_err    out  1   1-cycle pulse: jr_target[1:0]!=0 on a taken JR
// BEHAVIOUR
//  Reset (sync, any state incl. mid-fetch): pc=RESET_PC, state=FETCH, instruction=0,
//   instr_valid=0, align_err=0; imem_req=0 in the reset cycle; imem_ready in that cycle ignored.
//  FSM, 2 states:
//   FETCH: imem_req=1, imem_addr=pc (stable until accepted). imem_ready=1 at edge ->
//     instruction<=imem_rdata, state<=HOLD. Else stay. Waits indefinitely.
//   HOLD: imem_req=0, instr_valid=1, instruction/pc_out stable. retire=1 at edge ->
//     pc<=next_pc, state<=FETCH. Else stay.
//  retire outside HOLD ignored; control inputs sampled only on retire&&HOLD.
//  Latency: ready same cycle as req -> instr_valid the next cycle; min 2 cycles/instr.
//  next_pc priority (fixed): jr > jump > branch-taken > pc_plus4.
//   jr:     {jr_target[31:2],2'b00}; if jr_target[1:0]!=0 pulse align_err next cycle.
//   jump:   {pc_plus4[31:28], instruction[25:0], 2'b00}.
//   branch: pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}.
//  Simultaneous jr&jump or jump&branch: priority above, no error flagged.
//  Arithmetic mod 2^32: pc 32'hFFFF_FFFC +4 -> 0; branch offsets wrap silently.
//  pc_plus4 combinational from pc_out; all other outputs registered or state-decoded.
// STRUCTURE
//  Shared package (cpu_defs): state encoding FETCH/HOLD; opcode constants OP_J=6'b000010,
//   OP_JAL=6'b000011, OP_BNE=6'b000101, OP_JR field; RESET_PC default. Used by decoder too.
//  One sub-module: next_pc_calc (combinational target mux + sign-extend/shift), unit-testable alone.
//  Top holds pc register, FSM, instruction register, align_err flop.
// TESTING
//  1 Reset then imem_ready=1 always -> cycle1 imem_req=1 addr 0; cycle2 instr_valid=1, instruction=rdata.
//  2 imem_ready low 3 cycles -> imem_addr held 0, instr_valid=0 until ready; then valid next cycle.
//  3 pc=0x40, instr BNE imm=0xFFFE, branch=1 alu_zero=0, retire -> next addr 0x3C; alu_zero=1 -> 0x44.
//  4 pc=0x1000_0000, J instr[25:0]=0x0000100, jump=1 retire -> addr 0x1000_0400; pc_plus4=0x1000_0004 at decode.
//  5 jr=1 jump=1 jr_target=0x0000_0202 retire -> addr 0x200, align_err=1 one cycle.
//  6 reset asserted in FETCH with imem_ready=1 same cycle -> instr_valid stays 0, next req addr RESET_PC;
//    pc=0xFFFF_FFFC retire plain -> next addr 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, opcode constants, reset PC, branch offset helper.
package cpu_defs;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_JAL   = 6'b000011;
    localparam logic [5:0]  OP_BNE   = 6'b000101;
    // JR is an R-type instruction identified by its funct field
    localparam logic [5:0]  FN_JR    = 6'b001000;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word-offset immediate -> signed byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// Combinational next-PC select: jr > jump > taken branch > sequential.
module next_pc_calc
    import cpu_defs::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Fixed-priority target mux; addition wraps mod 2^32
    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        if (jr) begin
            next_pc    = {jr_target[31:2], 2'b00};
            misaligned = |jr_target[1:0];
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_low, 2'b00};
        end else if (branch && !alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr_low[15:0]);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ready, holds the word for decode until retire.
module instruction_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        align_err
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         accept;
    logic         take;

    next_pc_calc u_next_pc (
        .pc_plus4   (pc_plus4),
        .instr_low  (instruction[25:0]),
        .branch     (branch),
        .alu_zero   (alu_zero),
        .jump       (jump),
        .jr         (jr),
        .jr_target  (jr_target),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // Next state and state-decoded outputs; req suppressed during the reset cycle
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        take        = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH: begin
                imem_req = !reset;
                if (imem_ready) begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (retire) begin
                    take      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // PC, instruction register and misaligned-JR pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instruction <= 32'h0;
            align_err   <= 1'b0;
        end else begin
            align_err <= take && misaligned;
            if (accept) instruction <= imem_rdata;
            if (take)   pc          <= next_pc;
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus4  = pc + 32'd4;

endmodule
